// File: rtl/adder_cla.sv
// adder_cla: two-level carry-lookahead adder, o_s/o_c = i_a + i_b + i_c (mod 2^NBIT).
// Latency: combinational (0 cycles); 1 cycle when ADDER_CLA_OREG_EN is defined.
// Backpressure: none; a new operand pair may be presented every cycle.
module adder_cla #(
  parameter int NBIT = 32,
  parameter int BLK  = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [NBIT-1:0] i_a,
  input  logic [NBIT-1:0] i_b,
  input  logic            i_c,
  output logic [NBIT-1:0] o_s,
  output logic            o_c
);

  // Number of 4-bit blocks and of super-groups (4 blocks each, last one may be partial).
  localparam int NB  = NBIT / BLK;
  localparam int NSG = (NB + 3) / 4;

  logic [NBIT-1:0]  g, p, c;
  // Block-level group generate/propagate, padded to whole super-groups with G=0, P=0.
  logic [NSG*4-1:0] bg, bp;
  // Block carry-ins; padded entries beyond NB are never consumed.
  logic [NSG*4-1:0] bc;
  // Super-group generate/propagate and super-group carry-ins.
  logic [NSG-1:0]   sg, sp, sc;
  logic [NBIT-1:0]  sum_c;
  logic             carry_c;

  // Bit-level generate/propagate.
  always_comb begin
    g = i_a & i_b;
    p = i_a ^ i_b;
  end

  // First level: group G/P per 4-bit block, flattened so no block ripples internally.
  always_comb begin
    bg = '0;
    bp = '0;
    for (int k = 0; k < NB; k++) begin
      bg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      bp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
    end
  end

  // Second level: super-group G/P, super carries chained from i_c, then block carry-ins.
  always_comb begin
    sg = '0;
    sp = '0;
    sc = '0;
    bc = '0;
    for (int j = 0; j < NSG; j++) begin
      sg[j] = bg[4*j+3]
            | (bp[4*j+3] & bg[4*j+2])
            | (bp[4*j+3] & bp[4*j+2] & bg[4*j+1])
            | (bp[4*j+3] & bp[4*j+2] & bp[4*j+1] & bg[4*j]);
      sp[j] = bp[4*j+3] & bp[4*j+2] & bp[4*j+1] & bp[4*j];
    end
    sc[0] = i_c;
    for (int j = 1; j < NSG; j++) begin
      sc[j] = sg[j-1] | (sp[j-1] & sc[j-1]);
    end
    for (int j = 0; j < NSG; j++) begin
      bc[4*j]   = sc[j];
      bc[4*j+1] = bg[4*j] | (bp[4*j] & sc[j]);
      bc[4*j+2] = bg[4*j+1] | (bp[4*j+1] & bg[4*j])
                | (bp[4*j+1] & bp[4*j] & sc[j]);
      bc[4*j+3] = bg[4*j+2] | (bp[4*j+2] & bg[4*j+1])
                | (bp[4*j+2] & bp[4*j+1] & bg[4*j])
                | (bp[4*j+2] & bp[4*j+1] & bp[4*j] & sc[j]);
    end
  end

  // In-block carries from the block carry-in, then sum bits and carry-out of the top block.
  always_comb begin
    c = '0;
    for (int k = 0; k < NB; k++) begin
      c[4*k]   = bc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & bc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
    end
    sum_c   = p ^ c;
    carry_c = bg[NB-1] | (bp[NB-1] & bc[NB-1]);
  end

`ifdef ADDER_CLA_OREG_EN
  // Output register; reset clears immediately and drops any in-flight result.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_s <= '0;
      o_c <= 1'b0;
    end else begin
      o_s <= sum_c;
      o_c <= carry_c;
    end
  end

  logic unused_sig;
  assign unused_sig = ^{sg[NSG-1], sp[NSG-1], bc};
`else
  // Combinational build: clock and reset are present only for a uniform interface.
  assign o_s = sum_c;
  assign o_c = carry_c;

  logic unused_sig;
  assign unused_sig = ^{i_clk, i_rstn, sg[NSG-1], sp[NSG-1], bc};
`endif

endmodule

// File: tb/tb_adder_cla.sv
// tb_adder_cla: scoreboard bench for adder_cla, directed plus random vectors.
// Latency: follows the build (0 cycles, or 1 cycle with ADDER_CLA_OREG_EN).
// Backpressure: none; one vector per clock.
module tb_adder_cla;

  localparam int NBIT = 32;
`ifdef ADDER_CLA_OREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic            clk;
  logic            rstn;
  logic [NBIT-1:0] a, b;
  logic            cin;
  logic [NBIT-1:0] s;
  logic            cout;

  logic [NBIT:0]   exp_q[$];
  int              n_chk  = 0;
  int              n_pass = 0;

  adder_cla #(.NBIT(NBIT)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .i_a   (a),
    .i_b   (b),
    .i_c   (cin),
    .o_s   (s),
    .o_c   (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NBIT:0] obs, input logic [NBIT:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got {c,s}=%h expected %h", tag, obs, expv);
  endtask

  // Drive one vector at the falling edge, push its golden result, compare when due.
  task automatic apply(input string tag, input logic [NBIT-1:0] va,
                       input logic [NBIT-1:0] vb, input logic vc);
    logic [NBIT:0] e;
    @(negedge clk);
    a   = va;
    b   = vb;
    cin = vc;
    exp_q.push_back({1'b0, va} + {1'b0, vb} + {{NBIT{1'b0}}, vc});
    if (LAT != 0) @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, {cout, s}, {(NBIT+1){1'bx}});
    end else begin
      e = exp_q.pop_front();
      chk(tag, {cout, s}, e);
    end
  endtask

  initial begin
    logic [NBIT:0] e;
    rstn = 1'b0;
    a    = '0;
    b    = '0;
    cin  = 1'b0;
    #1;
    chk("reset", {cout, s}, '0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    apply("zero",      32'h0000_0000, 32'h0000_0000, 1'b0);
    apply("blk_cross", 32'h0000_000F, 32'h0000_0001, 1'b0);
    apply("wrap",      32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    apply("all_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    apply("sg_cross",  32'h0000_FFFF, 32'h0000_0001, 1'b0);
    apply("mid_chain", 32'h00FF_FFF0, 32'h0000_0010, 1'b0);
    apply("top_gen",   32'h8000_0000, 32'h8000_0000, 1'b0);

    for (int i = 0; i < 30; i++) begin
      apply("rand", $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    // Mid-stream reset: registered build must clear immediately; combinational ignores it.
    @(negedge clk);
    a   = 32'h1234_5678;
    b   = 32'hF000_0001;
    cin = 1'b1;
    e   = {1'b0, a} + {1'b0, b} + 33'd1;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    if (LAT != 0) chk("rst_mid", {cout, s}, '0);
    else          chk("rst_ignored", {cout, s}, e);
    @(posedge clk);
    #1;
    if (LAT != 0) chk("rst_hold", {cout, s}, '0);
    else          chk("rst_hold_comb", {cout, s}, e);
    @(negedge clk);
    rstn = 1'b1;

    apply("post_rst", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
